// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Contents: FSM state enum (4-bit), opcode and funct constants,
// aluop encoding and alucontrol encodings.
package mc_pkg;

   // FETCH..JEX keep their historical codes 0..11; BNEEX is appended as 12.
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11,
      BNEEX   = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
// Datapath (master) drives op, funct, zero; controller (slave) drives
// pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
// alusrcb, pcsrc, alucontrol and the debug state_o.
interface multicycle_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state_o;

   modport master (
      output op, funct, zero,
      input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, state_o
   );

   modport slave (
      input  op, funct, zero,
      output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, state_o
   );
endinterface

// File: rtl/aludec.sv
// ALU decoder: maps aluop (and funct for R-type) to alucontrol.
// Ports: i_aluop (2), i_funct (6) in; o_alucontrol (3) out.
// Unknown funct / aluop yields X so downstream logic may optimise freely.
module aludec
   import mc_pkg::*;
(
   input  aluop_t     i_aluop,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alucontrol
);
   always_comb begin
      o_alucontrol = 'x;
      case (i_aluop)
         ALUOP_ADD: o_alucontrol = ALU_ADD;
         ALUOP_SUB: o_alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct)
               F_ADD:   o_alucontrol = ALU_ADD;
               F_SUB:   o_alucontrol = ALU_SUB;
               F_AND:   o_alucontrol = ALU_AND;
               F_OR:    o_alucontrol = ALU_OR;
               F_SLT:   o_alucontrol = ALU_SLT;
               default: o_alucontrol = 'x;
            endcase
         end
         default: o_alucontrol = 'x;
      endcase
   end
endmodule

// File: rtl/mc_mainfsm.sv
// Main sequencing FSM of the multicycle controller (Moore).
// Ports: i_clk, i_reset (sync, active-high), i_op in; o_state, mux selects,
// write enables (irwrite/memwrite/regwrite masked during reset), and the
// internal o_aluop / o_branch / o_bne / o_pcwrite used by the top level.
module mc_mainfsm
   import mc_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [5:0] i_op,
   output logic [3:0] o_state,
   output logic       o_iord,
   output logic       o_memwrite,
   output logic       o_irwrite,
   output logic       o_regdst,
   output logic       o_memtoreg,
   output logic       o_regwrite,
   output logic       o_alusrca,
   output logic [1:0] o_alusrcb,
   output logic [1:0] o_pcsrc,
   output aluop_t     o_aluop,
   output logic       o_branch,
   output logic       o_bne,
   output logic       o_pcwrite
);
   state_t r_state;
   state_t w_next;
   logic   w_memwrite;
   logic   w_irwrite;
   logic   w_regwrite;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= FETCH;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next     = FETCH;
      o_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      o_regdst   = 1'b0;
      o_memtoreg = 1'b0;
      w_regwrite = 1'b0;
      o_alusrca  = 1'b0;
      o_alusrcb  = 2'b00;
      o_pcsrc    = 2'b00;
      o_aluop    = ALUOP_ADD;
      o_branch   = 1'b0;
      o_bne      = 1'b0;
      o_pcwrite  = 1'b0;
      case (r_state)
         FETCH: begin
            o_alusrcb = 2'b01;
            w_irwrite = 1'b1;
            o_pcwrite = 1'b1;
            w_next    = DECODE;
         end
         DECODE: begin
            o_alusrcb = 2'b11;
            case (i_op)
               OP_LW, OP_SW: w_next = MEMADR;
               OP_RTYPE:     w_next = EXECUTE;
               OP_BEQ:       w_next = BEQEX;
               OP_BNE:       w_next = BNEEX;
               OP_ADDI:      w_next = ADDIEX;
               OP_J:         w_next = JEX;
               default:      w_next = FETCH;
            endcase
         end
         MEMADR: begin
            o_alusrca = 1'b1;
            o_alusrcb = 2'b10;
            w_next    = (i_op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            o_iord = 1'b1;
            w_next = MEMWB;
         end
         MEMWB: begin
            o_memtoreg = 1'b1;
            w_regwrite = 1'b1;
         end
         MEMWR: begin
            o_iord     = 1'b1;
            w_memwrite = 1'b1;
         end
         EXECUTE: begin
            o_alusrca = 1'b1;
            o_aluop   = ALUOP_FUNCT;
            w_next    = ALUWB;
         end
         ALUWB: begin
            o_regdst   = 1'b1;
            w_regwrite = 1'b1;
         end
         BEQEX: begin
            o_alusrca = 1'b1;
            o_aluop   = ALUOP_SUB;
            o_pcsrc   = 2'b01;
            o_branch  = 1'b1;
         end
         BNEEX: begin
            o_alusrca = 1'b1;
            o_aluop   = ALUOP_SUB;
            o_pcsrc   = 2'b01;
            o_bne     = 1'b1;
         end
         ADDIEX: begin
            o_alusrca = 1'b1;
            o_alusrcb = 2'b10;
            w_next    = ADDIWB;
         end
         ADDIWB: begin
            w_regwrite = 1'b1;
         end
         JEX: begin
            o_pcsrc   = 2'b10;
            o_pcwrite = 1'b1;
         end
         default: w_next = FETCH;
      endcase
   end

   // Architectural writes are blocked in the reset cycle itself, not just after it.
   assign o_irwrite  = w_irwrite  & ~i_reset;
   assign o_memwrite = w_memwrite & ~i_reset;
   assign o_regwrite = w_regwrite & ~i_reset;
   assign o_state    = r_state;
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller top level.
// Ports: clk, reset (sync, active-high) and the controller bus (slave side)
// carrying op/funct/zero in and all datapath controls plus state_o out.
// Holds only the PC-enable logic; sequencing lives in mc_mainfsm,
// ALU control in aludec.
module multicycle_controller
   import mc_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   multicycle_controller_if.slave       bus
);
   aluop_t w_aluop;
   logic   w_branch;
   logic   w_bne;
   logic   w_pcwrite;

   mc_mainfsm u_mainfsm (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_op       (bus.op),
      .o_state    (bus.state_o),
      .o_iord     (bus.iord),
      .o_memwrite (bus.memwrite),
      .o_irwrite  (bus.irwrite),
      .o_regdst   (bus.regdst),
      .o_memtoreg (bus.memtoreg),
      .o_regwrite (bus.regwrite),
      .o_alusrca  (bus.alusrca),
      .o_alusrcb  (bus.alusrcb),
      .o_pcsrc    (bus.pcsrc),
      .o_aluop    (w_aluop),
      .o_branch   (w_branch),
      .o_bne      (w_bne),
      .o_pcwrite  (w_pcwrite)
   );

   aludec u_aludec (
      .i_aluop      (w_aluop),
      .i_funct      (bus.funct),
      .o_alucontrol (bus.alucontrol)
   );

   assign bus.pcen = (w_pcwrite | (w_branch & bus.zero) | (w_bne & ~bus.zero)) & ~reset;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model
// builds the expected state walk per opcode and the expected controls per
// step; one negedge process compares every cycle. Per-instruction literal
// counts (cycles, irwrite/regwrite/memwrite/pcen pulses) pin the model.
module tb_multicycle_controller;
   import mc_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_controller_if bus();

   multicycle_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic [2:0] alu;
   } obs_t;

   obs_t  expq[$];
   string lit_nm[$];
   int    lit_act[$];
   int    lit_exp[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   obs_t  cmp_e, cmp_a;

   state_t m_seq[6];
   int     m_len;
   int     c_cyc, c_rw, c_mw, c_ir, c_pc;

   // Expected controls for one cycle, straight from the per-state table.
   function automatic obs_t model(state_t s, logic [5:0] fn, logic z, logic rst);
      obs_t e;
      e = '0;
      e.st  = s;
      e.alu = 3'b010;
      case (s)
         FETCH:   begin e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1; end
         DECODE:  e.alusrcb = 2'b11;
         MEMADR:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         MEMRD:   e.iord = 1'b1;
         MEMWB:   begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
         MEMWR:   begin e.iord = 1'b1; e.memwrite = 1'b1; end
         EXECUTE: begin
            e.alusrca = 1'b1;
            case (fn)
               6'b100000: e.alu = 3'b010;
               6'b100010: e.alu = 3'b110;
               6'b100100: e.alu = 3'b000;
               6'b100101: e.alu = 3'b001;
               default:   e.alu = 3'b111;
            endcase
         end
         ALUWB:   begin e.regdst = 1'b1; e.regwrite = 1'b1; end
         BEQEX:   begin e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alu = 3'b110; e.pcen = z; end
         BNEEX:   begin e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alu = 3'b110; e.pcen = ~z; end
         ADDIEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         ADDIWB:  e.regwrite = 1'b1;
         JEX:     begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
         default: ;
      endcase
      if (rst) begin
         e.pcen = 1'b0; e.irwrite = 1'b0; e.memwrite = 1'b0; e.regwrite = 1'b0;
      end
      return e;
   endfunction

   // Steps following FETCH for a given opcode.
   function void build_seq(input logic [5:0] op);
      m_seq[0] = DECODE;
      m_len = 1;
      case (op)
         6'b100011: begin m_seq[1] = MEMADR; m_seq[2] = MEMRD; m_seq[3] = MEMWB; m_len = 4; end
         6'b101011: begin m_seq[1] = MEMADR; m_seq[2] = MEMWR; m_len = 3; end
         6'b000000: begin m_seq[1] = EXECUTE; m_seq[2] = ALUWB; m_len = 3; end
         6'b000100: begin m_seq[1] = BEQEX; m_len = 2; end
         6'b000101: begin m_seq[1] = BNEEX; m_len = 2; end
         6'b001000: begin m_seq[1] = ADDIEX; m_seq[2] = ADDIWB; m_len = 3; end
         6'b000010: begin m_seq[1] = JEX; m_len = 2; end
         default:   m_len = 1;
      endcase
   endfunction

   task automatic step(state_t s, logic [5:0] o, logic [5:0] fn, logic z, logic rst);
      @(posedge clk);
      #1;
      bus.op    = o;
      bus.funct = fn;
      bus.zero  = z;
      reset     = rst;
      expq.push_back(model(s, fn, z, rst));
      #1;
      if (bus.state_o == 4'(FETCH)) begin
         c_cyc = 0; c_rw = 0; c_mw = 0; c_ir = 0; c_pc = 0;
      end
      c_cyc++;
      c_rw += int'(bus.regwrite);
      c_mw += int'(bus.memwrite);
      c_ir += int'(bus.irwrite);
      c_pc += int'(bus.pcen);
   endtask

   task automatic lit(string nm, int act, int exp);
      lit_nm.push_back(nm);
      lit_act.push_back(act);
      lit_exp.push_back(exp);
   endtask

   task automatic do_instr(string nm, logic [5:0] op, logic [5:0] fn, logic z,
                           int e_cyc, int e_rw, int e_mw, int e_pc);
      build_seq(op);
      step(FETCH, op, fn, z, 1'b0);
      for (int i = 0; i < m_len; i++) step(m_seq[i], op, fn, z, 1'b0);
      lit({nm, " cycles"},   c_cyc, e_cyc);
      lit({nm, " irwrite"},  c_ir,  1);
      lit({nm, " regwrite"}, c_rw,  e_rw);
      lit({nm, " memwrite"}, c_mw,  e_mw);
      lit({nm, " pcen"},     c_pc,  e_pc);
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         cmp_e = expq.pop_front();
         cmp_a.st       = bus.state_o;
         cmp_a.pcen     = bus.pcen;
         cmp_a.iord     = bus.iord;
         cmp_a.memwrite = bus.memwrite;
         cmp_a.irwrite  = bus.irwrite;
         cmp_a.regdst   = bus.regdst;
         cmp_a.memtoreg = bus.memtoreg;
         cmp_a.regwrite = bus.regwrite;
         cmp_a.alusrca  = bus.alusrca;
         cmp_a.alusrcb  = bus.alusrcb;
         cmp_a.pcsrc    = bus.pcsrc;
         cmp_a.alu      = bus.alucontrol;
         n_tests++;
         if (cmp_a !== cmp_e) begin
            n_fail++;
            $display("FAIL ctrl@%0t state=%0d: got %b required %b (st|pcen iord mw irw rdst m2r rw asa|asb|pcsrc|alu)",
                     $time, cmp_e.st, cmp_a, cmp_e);
         end
      end
      while (lit_nm.size() > 0) begin
         n_tests++;
         if (lit_act[0] != lit_exp[0]) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", lit_nm[0], lit_act[0], lit_exp[0]);
         end
         void'(lit_nm.pop_front());
         void'(lit_act.pop_front());
         void'(lit_exp.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      bus.op    = '0;
      bus.funct = '0;
      bus.zero  = 1'b0;
      step(FETCH, 6'b0, 6'b0, 1'b0, 1'b1);
      step(FETCH, 6'b0, 6'b0, 1'b0, 1'b1);

      //          name     op          funct       z   cyc rw mw pc
      do_instr("lw",     6'b100011, 6'b000000, 1'b0, 5, 1, 0, 1);

      // reset held 3 cycles starting in DECODE of an lw
      step(FETCH,  6'b100011, 6'b0, 1'b0, 1'b0);
      step(DECODE, 6'b100011, 6'b0, 1'b0, 1'b1);
      step(FETCH,  6'b100011, 6'b0, 1'b0, 1'b1);
      step(FETCH,  6'b100011, 6'b0, 1'b0, 1'b1);
      lit("reset regwrite", c_rw, 0);

      do_instr("sub",    6'b000000, 6'b100010, 1'b0, 4, 1, 0, 1);
      do_instr("add",    6'b000000, 6'b100000, 1'b0, 4, 1, 0, 1);
      do_instr("and",    6'b000000, 6'b100100, 1'b0, 4, 1, 0, 1);
      do_instr("or",     6'b000000, 6'b100101, 1'b0, 4, 1, 0, 1);
      do_instr("slt",    6'b000000, 6'b101010, 1'b1, 4, 1, 0, 1);
      do_instr("beq z1", 6'b000100, 6'b000000, 1'b1, 3, 0, 0, 2);
      do_instr("beq z0", 6'b000100, 6'b000000, 1'b0, 3, 0, 0, 1);
      do_instr("bne z1", 6'b000101, 6'b000000, 1'b1, 3, 0, 0, 1);
      do_instr("bne z0", 6'b000101, 6'b000000, 1'b0, 3, 0, 0, 2);
      do_instr("j",      6'b000010, 6'b000000, 1'b0, 3, 0, 0, 2);
      do_instr("illegal",6'b111111, 6'b000000, 1'b0, 2, 0, 0, 1);
      do_instr("sw",     6'b101011, 6'b000000, 1'b0, 4, 0, 1, 1);
      do_instr("addi",   6'b001000, 6'b000000, 1'b0, 4, 1, 0, 1);

      // Final instruction's last step is followed by a FETCH.
      step(FETCH, 6'b0, 6'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      lit("queue drained", expq.size(), 0);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
